allophone_feeder: RTL and testbench

//  Host-side transmitter for the Speech256 allophone load interface (ldq / data_in / data_stb).
//  A host (UART/SPI bridge, ROM sequencer) pushes 6-bit allophone codes into an internal FIFO.
//  The block forwards them one at a time to the speech core whenever the core raises ldq.
//  It strobes each code once, then waits for ldq to drop before it may send the next code.
//

---
 rtl/allophone_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_allophone_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/allophone_feeder.sv
// allophone_feeder: host-side FIFO plus load handshake for the Speech256 core.
// The host pushes 6-bit allophone codes. Each code is strobed to the core once
// per ldq high phase, and the block then waits for ldq to fall (or time out).
module allophone_feeder #(
  parameter int DEPTH       = 16,
  parameter int LDQ_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_an,
  input  logic [5:0]               wr_data,
  input  logic                     wr_en,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic                     ldq,
  output logic [5:0]               data_out,
  output logic                     data_stb,
  output logic                     busy,
  output logic                     ovf_err,
  output logic                     tmo_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TMO_LAST = LDQ_TIMEOUT - 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_reg;
  // Registered non-empty flag: the FSM acts on it one cycle after a write
  // lands, which keeps the pop decision off the write path.
  logic          avail_reg;

  // Handshake FSM and registered outputs
  state_t        state_reg;
  logic [15:0]   timer_reg;
  logic [5:0]    data_out_reg;
  logic          data_stb_reg;
  logic          busy_reg;
  logic          ovf_err_reg;
  logic          tmo_err_reg;

  // Per-cycle events
  logic          push;
  logic          pop;
  logic          ovf_evt;
  logic          tmo_evt;

  // Decode push/pop/error events and the next occupancy
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    ovf_evt    = 1'b0;
    tmo_evt    = 1'b0;
    count_next = count_reg;

    // Fullness is judged on the current count, so a same-cycle pop never
    // makes room for a write arriving while full.
    if (!flush && wr_en) begin
      if (count_reg == CW'(DEPTH)) begin
        ovf_evt = 1'b1;
      end else begin
        push = 1'b1;
      end
    end

    if (!flush && (state_reg == IDLE) && ldq && avail_reg && (count_reg != '0)) begin
      pop = 1'b1;
    end

    if (!flush && (state_reg == WAIT_LOW) && ldq && (timer_reg == 16'(TMO_LAST))) begin
      tmo_evt = 1'b1;
    end

    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // FIFO array write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // FIFO pointers, occupancy, full and non-empty flags
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      avail_reg  <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      avail_reg  <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      avail_reg <= (count_reg != '0);
    end
  end

  // Load handshake FSM: pop on ldq, strobe once, wait for ldq low or timeout
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      data_out_reg <= '0;
      data_stb_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else if (flush) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      data_out_reg <= '0;
      data_stb_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            data_out_reg <= mem[rd_ptr_reg];
            data_stb_reg <= 1'b1;
            state_reg    <= STROBE;
            busy_reg     <= 1'b1;
          end else begin
            data_stb_reg <= 1'b0;
            busy_reg     <= (count_next != '0);
          end
        end

        STROBE: begin
          data_stb_reg <= 1'b0;
          timer_reg    <= '0;
          state_reg    <= WAIT_LOW;
          busy_reg     <= 1'b1;
        end

        WAIT_LOW: begin
          data_stb_reg <= 1'b0;
          if (!ldq || tmo_evt) begin
            state_reg <= IDLE;
            busy_reg  <= (count_next != '0);
          end else begin
            timer_reg <= timer_reg + 1'b1;
            busy_reg  <= 1'b1;
          end
        end

        default: begin
          data_stb_reg <= 1'b0;
          state_reg    <= IDLE;
          busy_reg     <= (count_next != '0);
        end
      endcase
    end
  end

  // Sticky error flags: a new event in the same cycle beats err_clr,
  // and flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst_an) begin
      ovf_err_reg <= 1'b0;
      tmo_err_reg <= 1'b0;
    end else begin
      ovf_err_reg <= ovf_evt | (ovf_err_reg & ~err_clr);
      tmo_err_reg <= tmo_evt | (tmo_err_reg & ~err_clr);
    end
  end

  assign fifo_full  = full_reg;
  assign fifo_count = count_reg;
  assign data_out   = data_out_reg;
  assign data_stb   = data_stb_reg;
  assign busy       = busy_reg;
  assign ovf_err    = ovf_err_reg;
  assign tmo_err    = tmo_err_reg;

endmodule

// File: tb/tb_allophone_feeder.sv
// Directed bench for allophone_feeder: one task per scenario, inline checks.
module tb_allophone_feeder;

  localparam int DEPTH       = 16;
  localparam int LDQ_TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_an;
  logic [5:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       err_clr;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       ldq;
  logic [5:0] data_out;
  logic       data_stb;
  logic       busy;
  logic       ovf_err;
  logic       tmo_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  allophone_feeder #(.DEPTH(DEPTH), .LDQ_TIMEOUT(LDQ_TIMEOUT)) dut (
    .clk        (clk),
    .rst_an     (rst_an),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .flush      (flush),
    .err_clr    (err_clr),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .ldq        (ldq),
    .data_out   (data_out),
    .data_stb   (data_stb),
    .busy       (busy),
    .ovf_err    (ovf_err),
    .tmo_err    (tmo_err)
  );

  always #5 clk = ~clk;

  // Reset: every output must be zero
  task automatic test_reset();
    logic [15:0] outs;
    rst_an = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; err_clr = 1'b0; ldq = 1'b0;
    repeat (2) @(negedge clk);
    outs = {fifo_full, fifo_count, data_out, data_stb, busy, ovf_err, tmo_err};
    vec_cnt++; if (outs !== 16'h0) begin err_cnt++; $display("FAIL reset_outputs: got %04h want 0000", outs); end
    $display("reset applied, outputs=%04h", outs);
    rst_an = 1'b1;
  endtask

  // Single code: strobe two edges after the write, width one, busy drops after ldq low
  task automatic test_single();
    ldq = 1'b1;
    @(negedge clk);
    wr_data = 6'h15; wr_en = 1'b1;
    @(negedge clk);                        // write edge n
    wr_en = 1'b0;
    vec_cnt++; if (data_stb !== 1'b0) begin err_cnt++; $display("FAIL single_stb_n: got %0b want 0", data_stb); end
    vec_cnt++; if (fifo_count !== 5'd1) begin err_cnt++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy_q: got %0b want 1", busy); end
    @(negedge clk);                        // edge n+1
    vec_cnt++; if (data_stb !== 1'b0) begin err_cnt++; $display("FAIL single_stb_n1: got %0b want 0", data_stb); end
    @(negedge clk);                        // edge n+2
    vec_cnt++; if (data_stb !== 1'b1) begin err_cnt++; $display("FAIL single_stb_n2: got %0b want 1", data_stb); end
    vec_cnt++; if (data_out !== 6'h15) begin err_cnt++; $display("FAIL single_data: got %02h want 15", data_out); end
    $display("single xfer: code 0x%02h", data_out);
    ldq = 1'b0;
    @(negedge clk);
    vec_cnt++; if (data_stb !== 1'b0) begin err_cnt++; $display("FAIL single_stb_width: got %0b want 0", data_stb); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy_wait: got %0b want 1", busy); end
    vec_cnt++; if (data_out !== 6'h15) begin err_cnt++; $display("FAIL single_data_hold: got %02h want 15", data_out); end
    @(negedge clk);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_idle: got %0b want 0", busy); end
    vec_cnt++; if (fifo_count !== 5'd0) begin err_cnt++; $display("FAIL single_count_end: got %0d want 0", fifo_count); end
  endtask

  // Fill to full with ldq low, overflow once, then drain in order with a core model
  task automatic test_fill_overflow();
    int got;
    int low;
    ldq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_data = 6'(i); wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    vec_cnt++; if (fifo_full !== 1'b1) begin err_cnt++; $display("FAIL fill_full: got %0b want 1", fifo_full); end
    vec_cnt++; if (fifo_count !== 5'd16) begin err_cnt++; $display("FAIL fill_count: got %0d want 16", fifo_count); end
    vec_cnt++; if (ovf_err !== 1'b0) begin err_cnt++; $display("FAIL fill_no_ovf: got %0b want 0", ovf_err); end
    vec_cnt++; if (data_stb !== 1'b0) begin err_cnt++; $display("FAIL fill_no_stb: got %0b want 0", data_stb); end
    wr_data = 6'h3F; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    vec_cnt++; if (ovf_err !== 1'b1) begin err_cnt++; $display("FAIL ovf_set: got %0b want 1", ovf_err); end
    vec_cnt++; if (fifo_count !== 5'd16) begin err_cnt++; $display("FAIL ovf_count: got %0d want 16", fifo_count); end

    got = 0; low = 0; ldq = 1'b1;
    for (int c = 0; c < 200 && got < 16; c++) begin
      @(negedge clk);
      if (data_stb) begin
        vec_cnt++; if (data_out !== 6'(got)) begin err_cnt++; $display("FAIL drain_order[%0d]: got %02h want %02h", got, data_out, 6'(got)); end
        $display("drain xfer %0d: code 0x%02h", got, data_out);
        got++; ldq = 1'b0; low = 2;
      end else if (low > 0) begin
        low--;
        if (low == 0) ldq = 1'b1;
      end
    end
    ldq = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (got !== 16) begin err_cnt++; $display("FAIL drain_total: got %0d want 16", got); end
    vec_cnt++; if (fifo_count !== 5'd0) begin err_cnt++; $display("FAIL drain_count: got %0d want 0", fifo_count); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL drain_busy: got %0b want 0", busy); end
  endtask

  // ldq stuck high after a strobe: timeout, then next code strobes, err_clr clears
  task automatic test_timeout();
    int cyc;
    int extra;
    bit found;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vec_cnt++; if (ovf_err !== 1'b0) begin err_cnt++; $display("FAIL errclr_ovf: got %0b want 0", ovf_err); end
    ldq = 1'b0;
    wr_data = 6'h2A; wr_en = 1'b1; @(negedge clk);
    wr_data = 6'h11; wr_en = 1'b1; @(negedge clk);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    ldq = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (data_stb) found = 1'b1;
    end
    vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL tmo_first_stb: got %0b want 1", found); end
    vec_cnt++; if (data_out !== 6'h2A) begin err_cnt++; $display("FAIL tmo_first_data: got %02h want 2a", data_out); end
    $display("tmo xfer: code 0x%02h", data_out);
    cyc = 0; extra = 0;
    while (!tmo_err && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (data_stb) extra++;
    end
    vec_cnt++; if (cyc !== LDQ_TIMEOUT + 1) begin err_cnt++; $display("FAIL tmo_cycles: got %0d want %0d", cyc, LDQ_TIMEOUT + 1); end
    vec_cnt++; if (extra !== 0) begin err_cnt++; $display("FAIL tmo_no_restrobe: got %0d want 0", extra); end
    @(negedge clk);
    vec_cnt++; if (data_stb !== 1'b1) begin err_cnt++; $display("FAIL tmo_next_stb: got %0b want 1", data_stb); end
    vec_cnt++; if (data_out !== 6'h11) begin err_cnt++; $display("FAIL tmo_next_data: got %02h want 11", data_out); end
    $display("tmo xfer: code 0x%02h", data_out);
    ldq = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vec_cnt++; if (tmo_err !== 1'b0) begin err_cnt++; $display("FAIL tmo_clear: got %0b want 0", tmo_err); end
    @(negedge clk);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL tmo_busy_end: got %0b want 0", busy); end
  endtask

  // 40 codes with the producer running as fast as fifo_full allows
  task automatic test_wrap();
    int sent;
    int got;
    int low;
    logic [5:0] want;
    sent = 0; got = 0; low = 0; ldq = 1'b1;
    for (int c = 0; c < 1000 && got < 40; c++) begin
      @(negedge clk);
      if (data_stb) begin
        want = 6'((got * 7 + 3) & 63);
        vec_cnt++; if (data_out !== want) begin err_cnt++; $display("FAIL wrap_order[%0d]: got %02h want %02h", got, data_out, want); end
        $display("wrap xfer %0d: code 0x%02h", got, data_out);
        got++; ldq = 1'b0; low = 2;
      end else if (low > 0) begin
        low--;
        if (low == 0) ldq = 1'b1;
      end
      if (sent < 40 && !fifo_full) begin
        wr_en = 1'b1; wr_data = 6'((sent * 7 + 3) & 63); sent++;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0; ldq = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (got !== 40) begin err_cnt++; $display("FAIL wrap_total: got %0d want 40", got); end
    vec_cnt++; if (ovf_err !== 1'b0) begin err_cnt++; $display("FAIL wrap_no_ovf: got %0b want 0", ovf_err); end
    vec_cnt++; if (fifo_count !== 5'd0) begin err_cnt++; $display("FAIL wrap_count: got %0d want 0", fifo_count); end
  endtask

  // flush plus wr_en while 5 entries are held and the FSM sits in WAIT_LOW
  task automatic test_flush();
    int stbs;
    ldq = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      wr_data = 6'(i); wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    ldq = 1'b1;
    @(negedge clk);
    vec_cnt++; if (data_stb !== 1'b1) begin err_cnt++; $display("FAIL flush_pre_stb: got %0b want 1", data_stb); end
    vec_cnt++; if (data_out !== 6'h01) begin err_cnt++; $display("FAIL flush_pre_data: got %02h want 01", data_out); end
    @(negedge clk);
    vec_cnt++; if (fifo_count !== 5'd5) begin err_cnt++; $display("FAIL flush_pre_count: got %0d want 5", fifo_count); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 6'h3F;
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    $display("flush applied, count=%0d data_out=0x%02h", fifo_count, data_out);
    vec_cnt++; if (fifo_count !== 5'd0) begin err_cnt++; $display("FAIL flush_count: got %0d want 0", fifo_count); end
    vec_cnt++; if (data_out !== 6'h00) begin err_cnt++; $display("FAIL flush_data: got %02h want 00", data_out); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL flush_busy: got %0b want 0", busy); end
    vec_cnt++; if (ovf_err !== 1'b0) begin err_cnt++; $display("FAIL flush_ovf: got %0b want 0", ovf_err); end
    stbs = 0;
    repeat (4) begin
      @(negedge clk);
      if (data_stb) stbs++;
    end
    vec_cnt++; if (stbs !== 0) begin err_cnt++; $display("FAIL flush_no_stb: got %0d want 0", stbs); end
    ldq = 1'b0;
  endtask

  // Reset asserted during STROBE; nothing sent until a fresh write
  task automatic test_reset_mid();
    logic [15:0] outs;
    int stbs;
    ldq = 1'b0;
    wr_data = 6'h0A; wr_en = 1'b1; @(negedge clk);
    wr_data = 6'h0B; wr_en = 1'b1; @(negedge clk);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    ldq = 1'b1;
    @(negedge clk);
    vec_cnt++; if (data_stb !== 1'b1) begin err_cnt++; $display("FAIL rstmid_stb: got %0b want 1", data_stb); end
    rst_an = 1'b0;
    @(negedge clk);
    outs = {fifo_full, fifo_count, data_out, data_stb, busy, ovf_err, tmo_err};
    vec_cnt++; if (outs !== 16'h0) begin err_cnt++; $display("FAIL rstmid_outputs: got %04h want 0000", outs); end
    $display("reset mid-transfer, outputs=%04h", outs);
    rst_an = 1'b1;
    stbs = 0;
    repeat (4) begin
      @(negedge clk);
      if (data_stb) stbs++;
    end
    vec_cnt++; if (stbs !== 0) begin err_cnt++; $display("FAIL rstmid_no_stb: got %0d want 0", stbs); end
    wr_data = 6'h07; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    vec_cnt++; if (data_stb !== 1'b0) begin err_cnt++; $display("FAIL rstmid_lat_n: got %0b want 0", data_stb); end
    @(negedge clk);
    vec_cnt++; if (data_stb !== 1'b0) begin err_cnt++; $display("FAIL rstmid_lat_n1: got %0b want 0", data_stb); end
    @(negedge clk);
    vec_cnt++; if (data_stb !== 1'b1) begin err_cnt++; $display("FAIL rstmid_lat_n2: got %0b want 1", data_stb); end
    vec_cnt++; if (data_out !== 6'h07) begin err_cnt++; $display("FAIL rstmid_data: got %02h want 07", data_out); end
    $display("post-reset xfer: code 0x%02h", data_out);
    ldq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_timeout();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
